// File: rtl/vga_tile_pkg.sv
// Shared screen/tile geometry and controller state encoding for the VGA tile path.
package vga_tile_pkg;

  localparam int unsigned TILE_SIZE = 160;
  localparam int unsigned TILE_COLS = 4;
  localparam int unsigned TILE_ROWS = 3;
  localparam int unsigned NUM_TILES = TILE_COLS * TILE_ROWS;
  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/tile_index_decoder.sv
// Combinational pixel (x,y) to row-major tile index; also used by the VGA output mux.
module tile_index_decoder
  import vga_tile_pkg::*;
(
  input  logic [9:0] x,
  input  logic [8:0] y,
  output logic [3:0] index,
  output logic       tileValid
);

  logic [1:0] col;
  logic [1:0] row;

  always_comb begin
    col = 2'd3;
    if (x < 10'(TILE_SIZE))          col = 2'd0;
    else if (x < 10'(2 * TILE_SIZE)) col = 2'd1;
    else if (x < 10'(3 * TILE_SIZE)) col = 2'd2;

    row = 2'd2;
    if (y < 9'(TILE_SIZE))          row = 2'd0;
    else if (y < 9'(2 * TILE_SIZE)) row = 2'd1;

    // row*4+col with four columns is plain concatenation
    index     = {row, col};
    tileValid = (x < 10'(SCREEN_W)) && (y < 9'(SCREEN_H));
  end

endmodule

// File: rtl/tile_reveal_controller.sv
// Frame-synchronous score tile reveal controller with a 1-cycle registered pixel enable.
module tile_reveal_controller
  import vga_tile_pkg::*;
#(
  parameter int unsigned FRAMES_PER_STEP = 8,
  parameter int unsigned SCORE_WIDTH     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SCORE_WIDTH-1:0] score,
  input  logic                   screenEnd,
  input  logic                   active,
  input  logic [9:0]             x,
  input  logic [8:0]             y,
  output logic [11:0]            tileMask,
  output logic [3:0]             revealedCount,
  output logic                   pixelOn,
  output logic                   busy,
  output logic                   allRevealed
);

  localparam int unsigned FCW = $clog2(FRAMES_PER_STEP) + 1;

  state_e         state_q, state_d;
  logic [3:0]     count_q, count_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic [11:0]    tile_mask_q, tile_mask_d;
  logic           busy_q, busy_d;
  logic           all_q, all_d;
  logic           pixel_on_q, pixel_on_d;

  logic [3:0]     target;
  logic [3:0]     tile_index;
  logic           tile_valid;

  tile_index_decoder u_decoder (
    .x         (x),
    .y         (y),
    .index     (tile_index),
    .tileValid (tile_valid)
  );

  always_comb begin
    target = (score > SCORE_WIDTH'(NUM_TILES)) ? 4'(NUM_TILES) : score[3:0];

    state_d     = state_q;
    count_d     = count_q;
    frame_cnt_d = frame_cnt_q;

    if (screenEnd) begin
      unique case (state_q)
        IDLE: begin
          if (target > count_q) begin
            frame_cnt_d = '0;
            state_d     = WAIT;
          end else if (target < count_q) begin
            count_d = target;
          end
        end
        WAIT: begin
          if (target < count_q) begin
            count_d     = target;
            frame_cnt_d = '0;
            state_d     = IDLE;
          end else if (target == count_q) begin
            state_d = IDLE;
          end else if (frame_cnt_q == FCW'(FRAMES_PER_STEP - 1)) begin
            count_d     = count_q + 4'd1;
            frame_cnt_d = '0;
            if (count_q + 4'd1 == target) state_d = IDLE;
          end else begin
            frame_cnt_d = frame_cnt_q + FCW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Registered status is derived from next-state so it stays in step with count
    for (int unsigned i = 0; i < NUM_TILES; i++) begin
      tile_mask_d[i] = (count_d > 4'(i));
    end
    busy_d     = (state_d == WAIT);
    all_d      = (count_d == 4'(NUM_TILES));
    pixel_on_d = active && tile_valid && tile_mask_q[tile_index];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      frame_cnt_q <= '0;
      tile_mask_q <= '0;
      busy_q      <= 1'b0;
      all_q       <= 1'b0;
      pixel_on_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      frame_cnt_q <= frame_cnt_d;
      tile_mask_q <= tile_mask_d;
      busy_q      <= busy_d;
      all_q       <= all_d;
      pixel_on_q  <= pixel_on_d;
    end
  end

  assign tileMask      = tile_mask_q;
  assign revealedCount = count_q;
  assign pixelOn       = pixel_on_q;
  assign busy          = busy_q;
  assign allRevealed   = all_q;

endmodule

// File: tb/tb_tile_reveal_controller.sv
// Scoreboard bench for tile_reveal_controller: a reference model pushes expectations per cycle.
module tb_tile_reveal_controller;

  localparam int unsigned FPS = 8;
  localparam int unsigned SW  = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [SW-1:0] score;
  logic          screenEnd;
  logic          active;
  logic [9:0]    x;
  logic [8:0]    y;
  logic [11:0]   tileMask;
  logic [3:0]    revealedCount;
  logic          pixelOn;
  logic          busy;
  logic          allRevealed;

  tile_reveal_controller #(
    .FRAMES_PER_STEP (FPS),
    .SCORE_WIDTH     (SW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .score         (score),
    .screenEnd     (screenEnd),
    .active        (active),
    .x             (x),
    .y             (y),
    .tileMask      (tileMask),
    .revealedCount (revealedCount),
    .pixelOn       (pixelOn),
    .busy          (busy),
    .allRevealed   (allRevealed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] mask;
    logic [3:0]  cnt;
    logic        busy;
    logic        all;
    logic        pix;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int unsigned m_count = 0;
  int unsigned m_fc    = 0;
  bit          m_wait  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [11:0] model_mask();
    logic [11:0] m;
    for (int i = 0; i < 12; i++) m[i] = (m_count > i);
    return m;
  endfunction

  task automatic step(input bit rst, input bit se);
    exp_t        e;
    logic [11:0] mk;
    int unsigned tgt;
    int unsigned idx;
    bit          vld;
    @(negedge clk);
    reset     = rst;
    screenEnd = se;
    mk  = model_mask();
    vld = (x < 640) && (y < 480);
    idx = (int'(y) / 160) * 4 + (int'(x) / 160);
    e.pix = (!rst && active && vld) ? mk[idx] : 1'b0;
    tgt = (score > 12) ? 12 : int'(score);
    if (rst) begin
      m_count = 0; m_fc = 0; m_wait = 1'b0;
    end else if (se) begin
      if (!m_wait) begin
        if (tgt > m_count) begin
          m_wait = 1'b1; m_fc = 0;
        end else if (tgt < m_count) begin
          m_count = tgt;
        end
      end else begin
        if (tgt < m_count) begin
          m_count = tgt; m_fc = 0; m_wait = 1'b0;
        end else if (tgt == m_count) begin
          m_wait = 1'b0;
        end else if (m_fc == FPS - 1) begin
          m_count++; m_fc = 0;
          if (m_count == tgt) m_wait = 1'b0;
        end else begin
          m_fc++;
        end
      end
    end
    e.mask = model_mask();
    e.cnt  = 4'(m_count);
    e.busy = m_wait;
    e.all  = (m_count == 12);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val("tileMask", 32'(tileMask), 32'(e.mask));
    check_val("revealedCount", 32'(revealedCount), 32'(e.cnt));
    check_val("busy", 32'(busy), 32'(e.busy));
    check_val("allRevealed", 32'(allRevealed), 32'(e.all));
    check_val("pixelOn", 32'(pixelOn), 32'(e.pix));
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  task automatic pix_probe(input string tag, input int px, input int py, input bit act, input bit want);
    x = 10'(px); y = 9'(py); active = act;
    step(1'b0, 1'b0);
    check_val(tag, 32'(pixelOn), 32'(want));
  endtask

  initial begin
    reset = 1'b1; score = '0; screenEnd = 1'b0; active = 1'b0; x = '0; y = '0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check_val("reset_mask", 32'(tileMask), 32'h0);
    check_val("reset_busy", 32'(busy), 32'h0);

    // slow reveal of three tiles
    score = 3;
    pulses(1);
    check_val("p1_busy", 32'(busy), 32'h1);
    pulses(7);
    check_val("p8_count", 32'(revealedCount), 32'd0);
    pulses(1);
    check_val("p9_count", 32'(revealedCount), 32'd1);
    pulses(8);
    check_val("p17_count", 32'(revealedCount), 32'd2);
    pulses(8);
    check_val("p25_count", 32'(revealedCount), 32'd3);
    check_val("p25_busy", 32'(busy), 32'h0);
    check_val("p25_mask", 32'(tileMask), 32'h007);

    // saturation at twelve tiles
    step(1'b1, 1'b0);
    score = 20;
    pulses(96);
    check_val("sat_p96_count", 32'(revealedCount), 32'd11);
    pulses(1);
    check_val("sat_count", 32'(revealedCount), 32'd12);
    check_val("sat_mask", 32'(tileMask), 32'hFFF);
    check_val("sat_all", 32'(allRevealed), 32'h1);
    check_val("sat_busy", 32'(busy), 32'h0);
    pulses(5);
    check_val("sat_hold", 32'(tileMask), 32'hFFF);

    // immediate decreases from IDLE and from mid-WAIT
    step(1'b1, 1'b0);
    score = 5;
    pulses(41);
    check_val("dec_pre_count", 32'(revealedCount), 32'd5);
    score = 2;
    pulses(1);
    check_val("dec_idle_count", 32'(revealedCount), 32'd2);
    check_val("dec_idle_mask", 32'(tileMask), 32'h003);
    check_val("dec_idle_busy", 32'(busy), 32'h0);
    score = 8;
    pulses(12);
    check_val("dec_wait_busy_pre", 32'(busy), 32'h1);
    check_val("dec_wait_count_pre", 32'(revealedCount), 32'd3);
    score = 1;
    pulses(1);
    check_val("dec_wait_count", 32'(revealedCount), 32'd1);
    check_val("dec_wait_busy", 32'(busy), 32'h0);

    // score churn without screenEnd
    for (int i = 0; i < 1000; i++) begin
      score = $urandom;
      step(1'b0, 1'b0);
    end
    check_val("churn_count", 32'(revealedCount), 32'd1);
    check_val("churn_mask", 32'(tileMask), 32'h001);

    // pixel enable with only tile 0 revealed
    step(1'b1, 1'b0);
    score = 1;
    pulses(9);
    check_val("pix_setup_mask", 32'(tileMask), 32'h001);
    pix_probe("pix_in_tile0", 100, 50, 1'b1, 1'b1);
    pix_probe("pix_tile1", 200, 50, 1'b1, 1'b0);
    pix_probe("pix_tile4", 100, 200, 1'b1, 1'b0);
    pix_probe("pix_inactive", 100, 50, 1'b0, 1'b0);
    pix_probe("pix_offscreen_x", 700, 50, 1'b1, 1'b0);
    pix_probe("pix_corner", 159, 159, 1'b1, 1'b1);
    pix_probe("pix_edge_x", 160, 0, 1'b1, 1'b0);
    pix_probe("pix_edge_y", 0, 160, 1'b1, 1'b0);
    score = 12;
    pulses(97);
    pix_probe("pix_last_tile", 639, 479, 1'b1, 1'b1);
    pix_probe("pix_offscreen_y", 10, 490, 1'b1, 1'b0);
    active = 1'b0;

    // reset mid-WAIT and coincident with screenEnd
    step(1'b1, 1'b0);
    score = 12;
    pulses(3);
    check_val("rst_wait_busy_pre", 32'(busy), 32'h1);
    step(1'b1, 1'b0);
    check_val("rst_wait_busy", 32'(busy), 32'h0);
    pulses(3);
    step(1'b1, 1'b1);
    check_val("rst_se_busy", 32'(busy), 32'h0);
    check_val("rst_se_count", 32'(revealedCount), 32'd0);
    score = 1;
    pulses(8);
    check_val("post_rst_p8", 32'(revealedCount), 32'd0);
    pulses(1);
    check_val("post_rst_p9", 32'(revealedCount), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_reveal_controller.md
Name: tile_reveal_controller

Overview:
Frame-synchronous controller that decides which of the 12 score tiles (4 cols x 3 rows, 160x160 px each) the VGA pixel path shows. It samples the game score at each frame boundary and animates reveals one tile per FRAMES_PER_STEP frames. It also produces a registered per-pixel enable aligned to the 1-cycle image/palette RAM read latency. It sits between the score source and the VGA output mux, driven by the timing generator's x, y, active and screenEnd.

Parameters:
FRAMES_PER_STEP, 8, frames between successive tile reveals (>=1)
SCORE_WIDTH, 32, width of score input

Ports:
clk  in  1  system/pixel clock
reset  in  1  synchronous, active-high reset
score  in  SCORE_WIDTH  current game score, unsigned
screenEnd  in  1  one-cycle pulse between frames
active  in  1  high while drawing visible pixels
x  in  10  pixel column from left
y  in  9  pixel row from top
tileMask  out  12  bit i high = tile i revealed (row-major, tile 0 top-left)
revealedCount  out  4  number of revealed tiles, 0..12
pixelOn  out  1  registered: current pixel lies in a revealed tile and active
busy  out  1  reveal animation in progress
allRevealed  out  1  revealedCount == 12

Behaviour:
- Clocking: single clock clk; reset synchronous, active-high; reset has priority over every other event, including a coincident screenEnd.
- Reset values: tileMask=0, revealedCount=0, pixelOn=0, busy=0, allRevealed=0, state=IDLE, frameCnt=0.
- target = min(score, 12). Computed combinationally and used only on screenEnd cycles; score changes between screenEnd pulses have no effect.
- FSM states IDLE, WAIT:
  - IDLE, screenEnd: if target>count, then frameCnt<=0 and go to WAIT. If target<count, then count<=target and stay in IDLE. If equal, no change.
  - WAIT, screenEnd: if target<count, then count<=target, frameCnt<=0, go to IDLE. Else if target==count, go to IDLE. Else if frameCnt==FRAMES_PER_STEP-1, then count<=count+1 and frameCnt<=0; go to IDLE if count+1==target. Otherwise frameCnt<=frameCnt+1.
  - No transitions on non-screenEnd cycles.
- Decreases are immediate (no animation). Increases are one tile per FRAMES_PER_STEP frames. First reveal occurs FRAMES_PER_STEP+1 screenEnd pulses after the increase is first sampled.
- tileMask is a thermometer code: bit i = (count > i). It updates in the same cycle as count, so it only changes on screenEnd, which prevents tearing.
- busy = (state==WAIT). allRevealed = (count==12). Both are registered outputs, consistent with count.
- Tile decode: col = 0/1/2/3 for x in [0,160)/[160,320)/[320,480)/[480,640); row = 0/1/2 for y in [0,160)/[160,320)/[320,480). index = row*4+col. The tile is invalid if x>=640 or y>=480.
- pixelOn(t+1) = active(t) & tileValid(t) & tileMask(t)[index(t)]. Latency is 1 cycle, matching RAM dataOut.
- Frame counter width is $clog2(FRAMES_PER_STEP)+1. With FRAMES_PER_STEP=1, the counter never increments, giving one reveal per screenEnd.

Decomposition:
- Package vga_tile_pkg holds:
  - TILE_SIZE=160, TILE_COLS=4, TILE_ROWS=3, NUM_TILES=12
  - SCREEN_W=640, SCREEN_H=480
  - state enum {IDLE, WAIT}
- Sub-module tile_index_decoder: combinational (x,y) -> (index[3:0], tileValid). It is reused by the VGA output mux.

Test Plan:
- Reset, score=3, then pulse screenEnd repeatedly -> busy=1 after pulse 1; revealedCount=1 after pulse 9, 2 after pulse 17, 3 after pulse 25; at pulse 25 busy=0 and tileMask=12'h007.
- score=20 -> saturates: revealedCount=12 after 97 pulses; tileMask=12'hFFF, allRevealed=1, busy=0; further pulses cause no change.
- count=5 in IDLE, score set to 2, one screenEnd -> revealedCount=2 and tileMask=12'h003 in that cycle; busy=0. Repeat mid-WAIT -> drops, state returns to IDLE.
- tileMask=12'h001: (x=100,y=50,active=1) -> pixelOn=1 next cycle; (x=200,y=50) -> 0; (x=100,y=200) -> 0; (x=100,y=50,active=0) -> 0; (x=700,y=50,active=1) -> 0.
- score changed with no screenEnd for 1000 cycles -> tileMask, revealedCount unchanged.
- reset asserted mid-WAIT, and reset coincident with screenEnd -> all outputs 0 next cycle, state IDLE; score=1 then requires 9 pulses to reveal tile 0.
